// File: rtl/ysyx_24070014_mem_arbiter.sv
// Arbitrates the single main-memory port between instruction fetch and load/store,
// one outstanding transaction at a time, with round-robin grant and response timeout.
//
// state | meaning
// IDLE  | no transaction; ready offered to the arbitration winner
// REQ   | latched request presented to memory until mem_req_ready
// RSP   | waiting for mem_rsp_valid or timeout
module ysyx_24070014_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    output logic                ifu_rsp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_rdata,
    output logic                lsu_rsp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,

    output logic                busy,
    output logic                spurious_err
);

    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             owner_lsu;
    logic             last_lsu;
    logic [TMR_W-1:0] timer;

    logic grant_ifu;
    logic grant_lsu;
    logic accept;
    logic rsp_hit;
    logic tmo_hit;
    logic done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        grant_ifu     = ifu_req_valid && (!lsu_req_valid || last_lsu);
        grant_lsu     = lsu_req_valid && (!ifu_req_valid || !last_lsu);
        // Gated by reset so no ready leaks out while the block is held in reset.
        ifu_req_ready = reset && (state == IDLE) && grant_ifu;
        lsu_req_ready = reset && (state == IDLE) && grant_lsu;
        accept        = ifu_req_ready || lsu_req_ready;
        rsp_hit       = (state == RSP) && mem_rsp_valid;
        tmo_hit       = (TIMEOUT != 0) && (state == RSP) && !mem_rsp_valid && (timer == TMR_LAST);
        done          = rsp_hit || tmo_hit;
        mem_req_valid = (state == REQ);
        busy          = (state != IDLE);
        state_nxt     = state;
        case (state)
            IDLE:    if (accept)        state_nxt = REQ;
            REQ:     if (mem_req_ready) state_nxt = RSP;
            RSP:     if (done)          state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_lsu     <= 1'b0;
            last_lsu      <= 1'b1;
            timer         <= '0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_err   <= 1'b0;
            ifu_rsp_data  <= '0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_err   <= 1'b0;
            lsu_rsp_rdata <= '0;
            spurious_err  <= 1'b0;
        end else begin
            ifu_rsp_valid <= done && !owner_lsu;
            ifu_rsp_err   <= tmo_hit && !owner_lsu;
            lsu_rsp_valid <= done && owner_lsu;
            lsu_rsp_err   <= tmo_hit && owner_lsu;
            if (done && !owner_lsu) begin
                ifu_rsp_data <= rsp_hit ? mem_rsp_rdata : '0;
            end
            if (done && owner_lsu) begin
                lsu_rsp_rdata <= rsp_hit ? mem_rsp_rdata : '0;
            end

            if (accept) begin
                owner_lsu <= lsu_req_ready;
                last_lsu  <= lsu_req_ready;
                if (lsu_req_ready) begin
                    mem_req_addr  <= lsu_req_addr;
                    mem_req_wen   <= lsu_req_wen;
                    mem_req_wdata <= lsu_req_wdata;
                    mem_req_wmask <= lsu_req_wmask;
                end else begin
                    mem_req_addr  <= ifu_req_addr;
                    mem_req_wen   <= 1'b0;
                    mem_req_wdata <= '0;
                    mem_req_wmask <= '0;
                end
            end

            // Saturating so a disabled timeout can never wrap into a false match.
            if ((state == REQ) && mem_req_ready) begin
                timer <= '0;
            end else if ((state == RSP) && !mem_rsp_valid && (timer != '1)) begin
                timer <= timer + TMR_W'(1);
            end

            if (mem_rsp_valid && (state != RSP)) begin
                spurious_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24070014_mem_arbiter.sv
// Scoreboard bench for the memory arbiter: directed transactions against a small memory model,
// responses checked by an independent monitor in issue order.
module tb_ysyx_24070014_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MW  = DW / 8;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic [AW-1:0] ifu_req_addr;
    logic [DW-1:0] ifu_rsp_data;
    logic          lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_err;
    logic [AW-1:0] lsu_req_addr;
    logic [DW-1:0] lsu_req_wdata, lsu_rsp_rdata;
    logic [MW-1:0] lsu_req_wmask;
    logic          mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata, mem_rsp_rdata;
    logic [MW-1:0] mem_req_wmask;
    logic          busy, spurious_err;

    ysyx_24070014_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .busy(busy), .spurious_err(spurious_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          lsu;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t push_e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rsp_cyc = 0;
    int rsp_count = 0;
    logic rsp_busy;

    // memory model configuration and observations
    int            cfg_ready_lat = 0;
    int            cfg_rsp_lat = 1;
    bit            cfg_silent = 0;
    logic [DW-1:0] cfg_xor = 32'h8000_0413;
    bit            inject_spur = 0;
    int            ready_cnt = 0, rsp_cnt = 0, lowcnt = 0, stab_bad = 0, hs_count = 0, hs_cyc = 0;
    bit            captured = 0;
    logic [AW-1:0] cap_addr, hs_addr;
    logic [DW-1:0] cap_wdata, hs_wdata;
    logic          cap_wen, hs_wen;
    logic [MW-1:0] cap_wmask, hs_wmask;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: ready after cfg_ready_lat low cycles, response cfg_rsp_lat cycles after handshake.
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (!reset) begin
                ready_cnt = 0;
                rsp_cnt = 0;
                captured = 0;
                inject_spur = 0;
            end else begin
                if (inject_spur) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = 32'h1234_5678;
                    inject_spur = 0;
                end
                if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0 && !cfg_silent) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_rdata = cap_addr ^ cfg_xor;
                    end
                end
                if (mem_req_valid) begin
                    if (!captured) begin
                        captured = 1;
                        cap_addr = mem_req_addr;
                        cap_wen = mem_req_wen;
                        cap_wdata = mem_req_wdata;
                        cap_wmask = mem_req_wmask;
                    end else if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !==
                                 {cap_addr, cap_wen, cap_wdata, cap_wmask}) begin
                        stab_bad++;
                    end
                    if (ready_cnt < cfg_ready_lat) begin
                        ready_cnt++;
                        lowcnt++;
                    end else begin
                        mem_req_ready = 1'b1;
                        ready_cnt = 0;
                        captured = 0;
                        rsp_cnt = cfg_rsp_lat;
                        hs_count++;
                        hs_cyc = cyc;
                        hs_addr = mem_req_addr;
                        hs_wen = mem_req_wen;
                        hs_wdata = mem_req_wdata;
                        hs_wmask = mem_req_wmask;
                    end
                end
            end
        end
    end

    // Monitor: every response pulse is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (reset && (ifu_rsp_valid || lsu_rsp_valid)) begin
            last_rsp_cyc = cyc;
            rsp_busy = busy;
            rsp_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: ifu_valid=%0b lsu_valid=%0b, expected no response",
                         ifu_rsp_valid, lsu_rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_port", {ifu_rsp_valid, lsu_rsp_valid}, mon_e.lsu ? 2'b01 : 2'b10);
                chk("rsp_data", mon_e.lsu ? lsu_rsp_rdata : ifu_rsp_data, mon_e.data);
                chk("rsp_err", mon_e.lsu ? lsu_rsp_err : ifu_rsp_err, mon_e.err);
                chk("rsp_other_err", mon_e.lsu ? ifu_rsp_err : lsu_rsp_err, 1'b0);
            end
        end
    end

    task automatic chk_zero(input string name);
        chk({name, "_ctrl"}, {ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, lsu_req_ready, lsu_rsp_valid,
                              lsu_rsp_err, mem_req_valid, mem_req_wen, busy, spurious_err}, 10'd0);
        chk({name, "_rspdata"}, {ifu_rsp_data, lsu_rsp_rdata}, 64'd0);
        chk({name, "_memreq"}, {mem_req_addr, mem_req_wdata}, 64'd0);
        chk({name, "_wmask"}, mem_req_wmask, 4'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        sb.delete();
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit lsu, input logic [AW-1:0] addr, input logic wen,
                         input logic [DW-1:0] wdata, input logic [MW-1:0] wmask,
                         input logic [DW-1:0] exp_data, input logic exp_err, output int acc);
        bit got = 0;
        acc = -1;
        if (lsu) begin
            lsu_req_valid = 1'b1;
            lsu_req_addr = addr;
            lsu_req_wen = wen;
            lsu_req_wdata = wdata;
            lsu_req_wmask = wmask;
        end else begin
            ifu_req_valid = 1'b1;
            ifu_req_addr = addr;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (lsu ? lsu_req_ready : ifu_req_ready) begin
                got = 1;
                acc = cyc;
                push_e.lsu = lsu;
                push_e.data = exp_data;
                push_e.err = exp_err;
                sb.push_back(push_e);
            end
        end
        chk("req_accepted", got, 1'b1);
        @(posedge clk);
        #1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic [1:0]    exp_gnt [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [DW-1:0] exp_dat [4] = '{32'h0000_0413, 32'h0000_0713, 32'h0000_0417, 32'h0000_0717};
    logic [1:0]    g;
    int            acc, hs0, rc0;
    bit            got;

    initial begin
        reset = 1'b1;
        ifu_req_valid = 1'b0; ifu_req_addr = '0;
        lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
        lsu_req_wdata = '0; lsu_req_wmask = '0;
        #1 reset = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #2 chk_zero("reset_init");
        repeat (2) @(negedge clk);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // IFU-only fetch, minimum latency
        issue(0, 32'h8000_0000, 0, '0, '0, 32'h0000_0413, 0, acc);
        wait_done();
        chk("ifu_latency", last_rsp_cyc - acc, 3);
        chk("ifu_mem_addr", hs_addr, 32'h8000_0000);
        chk("ifu_mem_wen_mask", {hs_wen, hs_wmask}, 5'd0);

        // Both requesting continuously: alternating grants starting with IFU
        do_reset();
        ifu_req_addr = 32'h8000_0000;
        lsu_req_addr = 32'h8000_0300;
        lsu_req_wen = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            g = 2'b00;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (ifu_req_ready || lsu_req_ready) begin
                    got = 1;
                    g = {ifu_req_ready, lsu_req_ready};
                end
            end
            chk("grant_seen", got, 1'b1);
            chk("grant_order", g, exp_gnt[k]);
            if (got) begin
                push_e.lsu = (exp_gnt[k] == 2'b01);
                push_e.data = exp_dat[k];
                push_e.err = 1'b0;
                sb.push_back(push_e);
            end
            @(posedge clk);
            #1;
            if (g[1]) ifu_req_addr = ifu_req_addr + 32'd4;
            if (g[0]) lsu_req_addr = lsu_req_addr + 32'd4;
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        wait_done();

        // LSU write with memory stalling ready for 5 cycles
        cfg_ready_lat = 5;
        lowcnt = 0;
        stab_bad = 0;
        hs0 = hs_count;
        issue(1, 32'h8000_0100, 1, 32'hDEAD_BEEF, 4'hF, 32'h0000_0513, 0, acc);
        wait_done();
        cfg_ready_lat = 0;
        chk("stall_low_cycles", lowcnt, 5);
        chk("stall_fields_stable", stab_bad, 0);
        chk("stall_handshakes", hs_count - hs0, 1);
        chk("stall_addr", hs_addr, 32'h8000_0100);
        chk("stall_wdata", hs_wdata, 32'hDEAD_BEEF);
        chk("stall_wen_mask", {hs_wen, hs_wmask}, 5'h1F);

        // Silent memory: timeout error 8 cycles after entering RSP, then normal service
        cfg_silent = 1;
        issue(0, 32'h8000_0040, 0, '0, '0, 32'h0000_0000, 1, acc);
        wait_done();
        cfg_silent = 0;
        chk("tmo_cycles", last_rsp_cyc - (hs_cyc + 1), 8);
        chk("tmo_busy_after", rsp_busy, 1'b0);
        issue(1, 32'h8000_0200, 0, '0, '0, 32'h0000_0613, 0, acc);
        wait_done();
        chk("post_tmo_latency", last_rsp_cyc - acc, 3);

        // Stray memory response while idle
        chk("spur_clear", spurious_err, 1'b0);
        rc0 = rsp_count;
        @(negedge clk);
        inject_spur = 1;
        repeat (4) @(negedge clk);
        chk("spur_set", spurious_err, 1'b1);
        chk("spur_no_rsp", rsp_count - rc0, 0);
        @(posedge clk);
        #1;
        issue(0, 32'h8000_0010, 0, '0, '0, 32'h0000_0403, 0, acc);
        wait_done();
        chk("spur_sticky", spurious_err, 1'b1);

        // Reset while waiting in RSP
        cfg_rsp_lat = 4;
        issue(0, 32'h8000_0060, 0, '0, '0, 32'h0000_0473, 0, acc);
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", {busy, mem_req_valid}, 2'b10);
        rc0 = rsp_count;
        ifu_req_addr = 32'h8000_0080;
        lsu_req_addr = 32'h8000_0300;
        lsu_req_wen = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #2 reset = 1'b0;
        sb.delete();
        #1 chk_zero("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        cfg_rsp_lat = 1;
        #1;
        chk("post_reset_grant", {ifu_req_ready, lsu_req_ready}, 2'b10);
        push_e.lsu = 1'b0;
        push_e.data = 32'h0000_0493;
        push_e.err = 1'b0;
        sb.push_back(push_e);
        acc = cyc;
        @(posedge clk);
        #1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        wait_done();
        chk("post_reset_latency", last_rsp_cyc - acc, 3);
        chk("post_reset_rsp_count", rsp_count - rc0, 1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
